register_file: RTL and testbench

REGISTER_FILE -- requirements
Module: register_file

---
 rtl/rf_pkg.sv | 11 +
 rtl/rf_read_port.sv | 32 +++
 rtl/register_file.sv | 68 ++++++
 tb/tb_register_file.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared constants and types for the register file.
package rf_pkg;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned ADDR_W_DEF = 5;
    localparam int unsigned NREGS      = 2 ** ADDR_W_DEF;

    typedef logic [ADDR_W_DEF-1:0] rf_addr_t;
    typedef logic [DATA_W_DEF-1:0] rf_data_t;

endpackage

// File: rtl/rf_read_port.sv
// One combinational read port: selects a register by address and forces x0 to zero.
// Macro REGISTER_FILE_BYPASS_EN adds write-through from the write port when addresses match.
module rf_read_port
    import rf_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic [2**ADDR_W-1:0][DATA_W-1:0] regs,
    input  logic [ADDR_W-1:0]                addr,
`ifdef REGISTER_FILE_BYPASS_EN
    input  logic                             wr_en,
    input  logic [ADDR_W-1:0]                wr_addr,
    input  logic [DATA_W-1:0]                wr_data,
`endif
    output logic [DATA_W-1:0]                data
);

    // Select the addressed register, optionally forward pending write data, mask x0 last.
    always_comb begin
        data = regs[addr];
`ifdef REGISTER_FILE_BYPASS_EN
        if (wr_en && (wr_addr != '0) && (wr_addr == addr)) begin
            data = wr_data;
        end
`endif
        if (addr == '0) begin
            data = '0;
        end
    end

endmodule

// File: rtl/register_file.sv
// Register file: 2**ADDR_W registers, two async read ports, one synchronous write port.
// x0 always reads zero. rst is asynchronous, active-low, and clears every register.
// Macro REGISTER_FILE_BYPASS_EN enables same-cycle write-through on both read ports.
module register_file
    import rf_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] A1,
    input  logic [ADDR_W-1:0] A2,
    input  logic [ADDR_W-1:0] A3,
    input  logic [DATA_W-1:0] WD3,
    input  logic              WE3,
    output logic [DATA_W-1:0] RD1,
    output logic [DATA_W-1:0] RD2
);

    localparam int unsigned N = 2 ** ADDR_W;

    logic [N-1:0][DATA_W-1:0] regs;

    // Storage: cleared asynchronously by reset, written on the rising edge; x0 is never written.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            regs <= '0;
        end else if (WE3 && (A3 != '0)) begin
            regs[A3] <= WD3;
        end
    end

`ifdef REGISTER_FILE_BYPASS_EN
    // Forwarding is suppressed during reset so reads stay zero while rst is low.
    logic wr_live;
    assign wr_live = WE3 & rst;
`endif

    rf_read_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_read_port1 (
        .regs    (regs),
        .addr    (A1),
`ifdef REGISTER_FILE_BYPASS_EN
        .wr_en   (wr_live),
        .wr_addr (A3),
        .wr_data (WD3),
`endif
        .data    (RD1)
    );

    rf_read_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_read_port2 (
        .regs    (regs),
        .addr    (A2),
`ifdef REGISTER_FILE_BYPASS_EN
        .wr_en   (wr_live),
        .wr_addr (A3),
        .wr_data (WD3),
`endif
        .data    (RD2)
    );

endmodule

// File: tb/tb_register_file.sv
// Directed self-checking bench for register_file (either build of REGISTER_FILE_BYPASS_EN).
module tb_register_file;
    import rf_pkg::*;

    logic     clk;
    logic     rst;
    rf_addr_t A1, A2, A3;
    rf_data_t WD3;
    logic     WE3;
    rf_data_t RD1, RD2;

    int unsigned checks = 0;
    int unsigned errors = 0;

    register_file #(
        .DATA_W (32),
        .ADDR_W (5)
    ) dut (
        .clk (clk),
        .rst (rst),
        .A1  (A1),
        .A2  (A2),
        .A3  (A3),
        .WD3 (WD3),
        .WE3 (WE3),
        .RD1 (RD1),
        .RD2 (RD2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got timeout expected finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held 60 ns, with a write attempt that must be ignored.
        rst = 1'b0; A1 = 5'd1; A2 = 5'd2; A3 = 5'd1; WD3 = 32'hDEAD_BEEF; WE3 = 1'b1;
        #2;
        check("rst_rd1_t2", RD1, 32'h0);
        check("rst_rd2_t2", RD2, 32'h0);
        after_edge();
        check("rst_rd1_e1", RD1, 32'h0);
        check("rst_rd2_e1", RD2, 32'h0);
        after_edge();
        check("rst_rd1_e2", RD1, 32'h0);
        WE3 = 1'b0;
        #(60 - $time);
        rst = 1'b1;
        after_edge();
        check("post_rst_rd1", RD1, 32'h0);
        check("post_rst_rd2", RD2, 32'h0);

        // WE3=0 must not store anything.
        @(negedge clk);
        A1 = 5'd5; A3 = 5'd5; WD3 = 32'd56; WE3 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            after_edge();
            check("we0_rd1", RD1, 32'h0);
        end

        // Write x5=56, then x4=26.
        @(negedge clk);
        WE3 = 1'b1;
        after_edge();
        check("wr_x5_rd1", RD1, 32'd56);
        @(negedge clk);
        A2 = 5'd4; A3 = 5'd4; WD3 = 32'd26;
        after_edge();
        check("wr_x4_rd2", RD2, 32'd26);
        check("wr_x4_rd1", RD1, 32'd56);

        // Write to x0 is discarded.
        @(negedge clk);
        A1 = 5'd0; A2 = 5'd0; A3 = 5'd0; WD3 = 32'hFFFF_FFFF;
        #1;
        check("x0_pre_rd1", RD1, 32'h0);
        after_edge();
        check("x0_rd1", RD1, 32'h0);
        check("x0_rd2", RD2, 32'h0);

        // Same address on both ports; other registers undisturbed.
        @(negedge clk);
        WE3 = 1'b0; A1 = 5'd4; A2 = 5'd4;
        #1;
        check("dual_rd1", RD1, 32'd26);
        check("dual_rd2", RD2, 32'd26);
        A1 = 5'd5;
        #1;
        check("x5_kept", RD1, 32'd56);

        // Full-width data and top address.
        @(negedge clk);
        A3 = 5'd9; WD3 = 32'h8000_0001; WE3 = 1'b1;
        after_edge();
        @(negedge clk);
        A3 = 5'd31; WD3 = 32'hFFFF_FFFF;
        after_edge();
        @(negedge clk);
        WE3 = 1'b0; A1 = 5'd9; A2 = 5'd31;
        #1;
        check("x9_full", RD1, 32'h8000_0001);
        check("x31_full", RD2, 32'hFFFF_FFFF);

        // WE3=0 with a live address and data leaves x9 unchanged.
        A3 = 5'd9; WD3 = 32'h0;
        after_edge();
        check("we0_x9", RD1, 32'h8000_0001);

        // Read of the write address in the write cycle.
        @(negedge clk);
        A1 = 5'd7; A3 = 5'd7; WD3 = 32'h0000_1234; WE3 = 1'b1;
        #1;
`ifdef REGISTER_FILE_BYPASS_EN
        check("x7_pre_edge", RD1, 32'h0000_1234);
`else
        check("x7_pre_edge", RD1, 32'h0);
`endif
        after_edge();
        check("x7_post_edge", RD1, 32'h0000_1234);

        // Mid-operation reset clears immediately; writes ignored until release.
        @(negedge clk);
        WE3 = 1'b0; A1 = 5'd5; A2 = 5'd4;
        #1;
        check("pre_pulse_rd1", RD1, 32'd56);
        check("pre_pulse_rd2", RD2, 32'd26);
        #1;
        rst = 1'b0;
        #1;
        check("pulse_rd1", RD1, 32'h0);
        check("pulse_rd2", RD2, 32'h0);
        A3 = 5'd5; WD3 = 32'd77; WE3 = 1'b1;
        after_edge();
        check("rst_wr_ignored", RD1, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        after_edge();
        check("first_wr_rd1", RD1, 32'd77);
        check("x4_cleared", RD2, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
